// File: rtl/health_manager_pkg.sv
// health_manager shared types: health width, FSM encoding, default parameters.
// Optional build macro HM_BLOCK_EN enables damage reduction while blocking.
package health_manager_pkg;

    localparam int HEALTH_W          = 5;
    localparam int MAX_HEALTH_DEF    = 20;
    localparam int IFRAME_TICKS_DEF  = 30;
    localparam int KO_HOLD_TICKS_DEF = 120;

    typedef logic [HEALTH_W-1:0] health_t;

    typedef enum logic [1:0] {
        FIGHT    = 2'd0,
        KO_DRAIN = 2'd1,
        KO_HOLD  = 2'd2,
        OVER     = 2'd3
    } hm_state_e;

    // Halved damage, but a nonzero hit never rounds down to nothing.
    function automatic health_t blocked_dmg(health_t dmg);
        health_t half;
        half = dmg >> 1;
        if (dmg != '0 && half == '0) begin
            half = health_t'(1);
        end
        return half;
    endfunction

    function automatic health_t sat_sub(health_t h, health_t d);
        return (h > d) ? health_t'(h - d) : '0;
    endfunction

endpackage

// File: rtl/health_manager_channel.sv
// health_channel: one player's health register, i-frame counter, block scaling.
// Block scaling exists only when HM_BLOCK_EN is defined.
module health_channel
    import health_manager_pkg::*;
#(
    parameter int MAX_HEALTH   = MAX_HEALTH_DEF,
    parameter int IFRAME_TICKS = IFRAME_TICKS_DEF
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    frame_tick_i,
    input  logic    fight_i,
    input  logic    restart_i,
    input  logic    hit_valid_i,
    input  health_t hit_dmg_i,
    input  logic    block_i,
    output logic    hit_ready_o,
    output health_t health_o
);

    localparam int IW = (IFRAME_TICKS < 1) ? 1 : $clog2(IFRAME_TICKS + 1);
    localparam logic [IW-1:0] IFRAME_LD = IW'(IFRAME_TICKS);

    health_t         health_q, health_d;
    logic [IW-1:0]   iframe_q, iframe_d;
    health_t         dmg_eff;
    logic            accept;

`ifdef HM_BLOCK_EN
    assign dmg_eff = block_i ? blocked_dmg(hit_dmg_i) : hit_dmg_i;
`else
    logic unused_block;
    assign unused_block = block_i;
    assign dmg_eff      = hit_dmg_i;
`endif

    assign hit_ready_o = fight_i && (iframe_q == '0);
    // A round restart in the same cycle discards the hit.
    assign accept      = hit_valid_i && hit_ready_o && !restart_i;
    assign health_o    = health_q;

    always_comb begin
        health_d = health_q;
        iframe_d = iframe_q;
        if (restart_i) begin
            health_d = health_t'(MAX_HEALTH);
            iframe_d = '0;
        end else if (accept) begin
            health_d = sat_sub(health_q, dmg_eff);
            if (dmg_eff != '0) begin
                iframe_d = IFRAME_LD;
            end
        end else if (frame_tick_i && iframe_q != '0) begin
            iframe_d = iframe_q - IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            health_q <= health_t'(MAX_HEALTH);
            iframe_q <= '0;
        end else begin
            health_q <= health_d;
            iframe_q <= iframe_d;
        end
    end

endmodule

// File: rtl/health_manager.sv
// health_manager: two health channels plus the round FSM (KO drain, hold, over).
// HM_BLOCK_EN (optional) enables blocked-damage halving in the channels.
module health_manager
    import health_manager_pkg::*;
#(
    parameter int MAX_HEALTH    = MAX_HEALTH_DEF,
    parameter int IFRAME_TICKS  = IFRAME_TICKS_DEF,
    parameter int KO_HOLD_TICKS = KO_HOLD_TICKS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                hit_valid_l,
    input  logic                hit_valid_r,
    input  logic [HEALTH_W-1:0] hit_dmg_l,
    input  logic [HEALTH_W-1:0] hit_dmg_r,
    output logic                hit_ready_l,
    output logic                hit_ready_r,
    input  logic                block_l,
    input  logic                block_r,
    input  logic                round_start,
    input  logic [HEALTH_W-1:0] final_health_l,
    input  logic [HEALTH_W-1:0] final_health_r,
    output logic [HEALTH_W-1:0] curr_health_l,
    output logic [HEALTH_W-1:0] curr_health_r,
    output logic                ko_l,
    output logic                ko_r,
    output logic                round_over
);

    localparam int KW = (KO_HOLD_TICKS < 1) ? 1 : $clog2(KO_HOLD_TICKS + 1);
    localparam logic [KW-1:0] HOLD_LD = KW'(KO_HOLD_TICKS);

    hm_state_e     state_q;
    logic [KW-1:0] hold_q;
    logic          ko_l_q, ko_r_q, round_over_q;
    logic          fight, dead_l, dead_r, drained;

    assign fight = (state_q == FIGHT);

    health_channel #(
        .MAX_HEALTH   (MAX_HEALTH),
        .IFRAME_TICKS (IFRAME_TICKS)
    ) u_chan_l (
        .clk          (clk),
        .reset        (reset),
        .frame_tick_i (frame_tick),
        .fight_i      (fight),
        .restart_i    (round_start),
        .hit_valid_i  (hit_valid_l),
        .hit_dmg_i    (hit_dmg_l),
        .block_i      (block_l),
        .hit_ready_o  (hit_ready_l),
        .health_o     (curr_health_l)
    );

    health_channel #(
        .MAX_HEALTH   (MAX_HEALTH),
        .IFRAME_TICKS (IFRAME_TICKS)
    ) u_chan_r (
        .clk          (clk),
        .reset        (reset),
        .frame_tick_i (frame_tick),
        .fight_i      (fight),
        .restart_i    (round_start),
        .hit_valid_i  (hit_valid_r),
        .hit_dmg_i    (hit_dmg_r),
        .block_i      (block_r),
        .hit_ready_o  (hit_ready_r),
        .health_o     (curr_health_r)
    );

    assign dead_l  = (curr_health_l == '0);
    assign dead_r  = (curr_health_r == '0);
    // Only knocked-out players need their status bar to finish draining.
    assign drained = (!dead_l || final_health_l == '0) &&
                     (!dead_r || final_health_r == '0);

    always_ff @(posedge clk) begin
        if (reset || round_start) begin
            state_q      <= FIGHT;
            hold_q       <= '0;
            ko_l_q       <= 1'b0;
            ko_r_q       <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            unique case (state_q)
                FIGHT: begin
                    if (dead_l || dead_r) begin
                        state_q <= KO_DRAIN;
                        ko_l_q  <= dead_l;
                        ko_r_q  <= dead_r;
                    end
                end
                KO_DRAIN: begin
                    ko_l_q <= ko_l_q | dead_l;
                    ko_r_q <= ko_r_q | dead_r;
                    if (drained) begin
                        state_q <= KO_HOLD;
                        hold_q  <= HOLD_LD;
                    end
                end
                KO_HOLD: begin
                    if (hold_q == '0) begin
                        state_q      <= OVER;
                        round_over_q <= 1'b1;
                    end else if (frame_tick) begin
                        hold_q <= hold_q - KW'(1);
                    end
                end
                OVER: begin
                    round_over_q <= 1'b1;
                end
                default: begin
                    state_q <= FIGHT;
                end
            endcase
        end
    end

    assign ko_l       = ko_l_q;
    assign ko_r       = ko_r_q;
    assign round_over = round_over_q;

endmodule

// File: tb/tb_health_manager.sv
// tb_health_manager: directed round scenarios then random play, checked
// against a rule-level reference model of both players and the round flow.
module tb_health_manager;

    localparam int MAXH = 20;
    localparam int IFR  = 30;
    localparam int KOH  = 120;

    localparam int P_FIGHT = 0;
    localparam int P_DRAIN = 1;
    localparam int P_HOLD  = 2;
    localparam int P_OVER  = 3;

    logic       clk = 1'b0;
    logic       reset, frame_tick, round_start;
    logic       hit_valid_l, hit_valid_r, block_l, block_r;
    logic [4:0] hit_dmg_l, hit_dmg_r, final_health_l, final_health_r;
    logic [4:0] curr_health_l, curr_health_r;
    logic       hit_ready_l, hit_ready_r, ko_l, ko_r, round_over;

    int n_cmp = 0;
    int n_err = 0;

    int m_hl, m_hr, m_ifl, m_ifr, m_hold, m_ph;
    bit m_kol, m_kor;

    always #5 clk = ~clk;

    health_manager #(
        .MAX_HEALTH    (MAXH),
        .IFRAME_TICKS  (IFR),
        .KO_HOLD_TICKS (KOH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .hit_valid_l    (hit_valid_l),
        .hit_valid_r    (hit_valid_r),
        .hit_dmg_l      (hit_dmg_l),
        .hit_dmg_r      (hit_dmg_r),
        .hit_ready_l    (hit_ready_l),
        .hit_ready_r    (hit_ready_r),
        .block_l        (block_l),
        .block_r        (block_r),
        .round_start    (round_start),
        .final_health_l (final_health_l),
        .final_health_r (final_health_r),
        .curr_health_l  (curr_health_l),
        .curr_health_r  (curr_health_r),
        .ko_l           (ko_l),
        .ko_r           (ko_r),
        .round_over     (round_over)
    );

    function automatic int eff_dmg(int d, bit blk);
        int r;
        r = d;
`ifdef HM_BLOCK_EN
        if (blk && d > 0) r = (d / 2 < 1) ? 1 : d / 2;
`else
        if (blk) r = d;
`endif
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hl = MAXH; m_hr = MAXH;
        m_ifl = 0; m_ifr = 0;
        m_hold = 0; m_ph = P_FIGHT;
        m_kol = 0; m_kor = 0;
    endtask

    // Next state from the rules, using the values seen before the edge.
    task automatic model_edge();
        int nhl, nhr, nifl, nifr, nhold, nph, e;
        bit nkol, nkor, fight;
        if (reset || round_start) begin
            model_reset();
        end else begin
            nhl = m_hl; nhr = m_hr; nifl = m_ifl; nifr = m_ifr;
            nhold = m_hold; nph = m_ph; nkol = m_kol; nkor = m_kor;
            fight = (m_ph == P_FIGHT);
            if (hit_valid_l && fight && m_ifl == 0) begin
                e = eff_dmg(int'(hit_dmg_l), block_l);
                nhl = (m_hl > e) ? m_hl - e : 0;
                if (e > 0) nifl = IFR;
            end else if (frame_tick && m_ifl > 0) begin
                nifl = m_ifl - 1;
            end
            if (hit_valid_r && fight && m_ifr == 0) begin
                e = eff_dmg(int'(hit_dmg_r), block_r);
                nhr = (m_hr > e) ? m_hr - e : 0;
                if (e > 0) nifr = IFR;
            end else if (frame_tick && m_ifr > 0) begin
                nifr = m_ifr - 1;
            end
            if (m_ph == P_FIGHT) begin
                if (m_hl == 0 || m_hr == 0) begin
                    nph = P_DRAIN;
                    nkol = (m_hl == 0);
                    nkor = (m_hr == 0);
                end
            end else if (m_ph == P_DRAIN) begin
                nkol = m_kol || (m_hl == 0);
                nkor = m_kor || (m_hr == 0);
                if ((m_hl != 0 || final_health_l == 0) &&
                    (m_hr != 0 || final_health_r == 0)) begin
                    nph = P_HOLD;
                    nhold = KOH;
                end
            end else if (m_ph == P_HOLD) begin
                if (m_hold == 0) nph = P_OVER;
                else if (frame_tick) nhold = m_hold - 1;
            end
            m_hl = nhl; m_hr = nhr; m_ifl = nifl; m_ifr = nifr;
            m_hold = nhold; m_ph = nph; m_kol = nkol; m_kor = nkor;
        end
    endtask

    task automatic check_all();
        chk("curr_health_l", 32'(curr_health_l), m_hl);
        chk("curr_health_r", 32'(curr_health_r), m_hr);
        chk("hit_ready_l", 32'(hit_ready_l), 32'(m_ph == P_FIGHT && m_ifl == 0));
        chk("hit_ready_r", 32'(hit_ready_r), 32'(m_ph == P_FIGHT && m_ifr == 0));
        chk("ko_l", 32'(ko_l), 32'(m_kol));
        chk("ko_r", 32'(ko_r), 32'(m_kor));
        chk("round_over", 32'(round_over), 32'(m_ph == P_OVER));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        reset = 0; frame_tick = 0; round_start = 0;
        hit_valid_l = 0; hit_valid_r = 0; block_l = 0; block_r = 0;
        hit_dmg_l = '0; hit_dmg_r = '0;
    endtask

    task automatic ticks(int n);
        frame_tick = 1;
        for (int i = 0; i < n; i++) step();
        frame_tick = 0;
    endtask

    initial begin
        idle_inputs();
        final_health_l = 5'd20;
        final_health_r = 5'd20;
        model_reset();

        reset = 1;
        step();
        step();
        reset = 0;
        chk("rst_health_l", 32'(curr_health_l), 20);
        chk("rst_ready_l", 32'(hit_ready_l), 1);
        chk("rst_round_over", 32'(round_over), 0);

        hit_valid_l = 1; hit_dmg_l = 5'd7;
        step();
        chk("hit7_health_l", 32'(curr_health_l), 13);
        hit_dmg_l = 5'd5;
        ticks(29);
        chk("iframe_ready_l", 32'(hit_ready_l), 0);
        chk("iframe_health_l", 32'(curr_health_l), 13);
        ticks(1);
        chk("iframe_end_ready_l", 32'(hit_ready_l), 1);
        hit_valid_l = 0;

        hit_valid_l = 1; hit_dmg_l = 5'd9; round_start = 1;
        step();
        idle_inputs();
        chk("restart_health_l", 32'(curr_health_l), 20);
        chk("restart_ready_l", 32'(hit_ready_l), 1);

        hit_valid_l = 1; block_l = 1; hit_dmg_l = 5'd7;
        step();
`ifdef HM_BLOCK_EN
        chk("block7_health_l", 32'(curr_health_l), 17);
`else
        chk("block7_health_l", 32'(curr_health_l), 13);
`endif
        idle_inputs();
        ticks(30);
        hit_valid_l = 1; block_l = 1; hit_dmg_l = 5'd1;
        step();
`ifdef HM_BLOCK_EN
        chk("block1_health_l", 32'(curr_health_l), 16);
`else
        chk("block1_health_l", 32'(curr_health_l), 12);
`endif
        idle_inputs();
        round_start = 1;
        step();
        round_start = 0;

        hit_valid_r = 1; hit_dmg_r = 5'd17;
        step();
        hit_valid_r = 0;
        chk("r_to_3", 32'(curr_health_r), 3);
        ticks(30);
        hit_valid_r = 1; hit_dmg_r = 5'd9;
        step();
        hit_valid_r = 0;
        chk("r_sat_0", 32'(curr_health_r), 0);
        final_health_r = 5'd5;
        step();
        chk("ko_r_set", 32'(ko_r), 1);
        chk("drain_ready_l", 32'(hit_ready_l), 0);
        step();
        final_health_r = 5'd0;
        step();
        ticks(KOH);
        chk("hold_not_over", 32'(round_over), 0);
        step();
        chk("round_over_set", 32'(round_over), 1);
        hit_valid_l = 1; hit_dmg_l = 5'd5;
        step();
        hit_valid_l = 0;
        chk("over_frozen_l", 32'(curr_health_l), 20);

        round_start = 1;
        step();
        round_start = 0;
        chk("over_restart_r", 32'(curr_health_r), 20);
        chk("over_restart_ko_r", 32'(ko_r), 0);
        chk("over_restart_ro", 32'(round_over), 0);
        chk("over_restart_ready_r", 32'(hit_ready_r), 1);

        hit_valid_l = 1; hit_valid_r = 1;
        hit_dmg_l = 5'd18; hit_dmg_r = 5'd18;
        step();
        hit_valid_l = 0; hit_valid_r = 0;
        ticks(30);
        hit_valid_l = 1; hit_valid_r = 1;
        hit_dmg_l = 5'd5; hit_dmg_r = 5'd5;
        step();
        hit_valid_l = 0; hit_valid_r = 0;
        chk("dko_health_l", 32'(curr_health_l), 0);
        chk("dko_health_r", 32'(curr_health_r), 0);
        step();
        chk("dko_ko_l", 32'(ko_l), 1);
        chk("dko_ko_r", 32'(ko_r), 1);

        reset = 1; round_start = 1;
        step();
        idle_inputs();
        chk("midko_reset_ko_l", 32'(ko_l), 0);
        chk("midko_reset_health_l", 32'(curr_health_l), 20);

        for (int c = 0; c < 4000; c++) begin
            int sel;
            reset       = ($urandom_range(0, 399) == 0);
            round_start = ($urandom_range(0, 299) == 0);
            frame_tick  = $urandom_range(0, 1);
            hit_valid_l = $urandom_range(0, 1);
            hit_valid_r = $urandom_range(0, 1);
            block_l     = $urandom_range(0, 1);
            block_r     = $urandom_range(0, 1);
            hit_dmg_l   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31)
                                                     : $urandom_range(0, 8));
            hit_dmg_r   = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31)
                                                     : $urandom_range(0, 8));
            sel = $urandom_range(0, 3);
            final_health_l = (sel == 0) ? 5'($urandom_range(0, 31)) :
                             (sel == 1) ? 5'(m_hl) : 5'd0;
            sel = $urandom_range(0, 3);
            final_health_r = (sel == 0) ? 5'($urandom_range(0, 31)) :
                             (sel == 1) ? 5'(m_hr) : 5'd0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
